// File: rtl/axis_sync_fifo.sv
// Single-clock first-word-fall-through AXI-Stream FIFO with DEPTH entries of DATA_WIDTH bits.
// Latency: a word accepted at edge N is presented on m_axis right after edge N; no comb path from s_axis to m_axis.
// Backpressure: s_axis_tready drops when full and returns the cycle after a pop; no pass-through when full.
// Optional build macro AXIS_FIFO_LEVEL_EN adds the level and almost_full outputs.
module axis_sync_fifo #(
    parameter int DATA_WIDTH = 16,
    parameter int DEPTH      = 16
) (
    input  logic                    clk,
    input  logic                    arstn,
    input  logic                    s_axis_tvalid,
    output logic                    s_axis_tready,
    input  logic [DATA_WIDTH-1:0]   s_axis_tdata,
    output logic                    m_axis_tvalid,
    input  logic                    m_axis_tready,
    output logic [DATA_WIDTH-1:0]   m_axis_tdata
`ifdef AXIS_FIFO_LEVEL_EN
    ,
    output logic [$clog2(DEPTH):0]  level,
    output logic                    almost_full
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam logic [PW-1:0] PTR_ONE = {{(PW-1){1'b0}}, 1'b1};

    // Reject depths the wrap-bit pointer scheme cannot represent.
    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("axis_sync_fifo: DEPTH must be a power of 2 and at least 2");
    end

    logic [PW-1:0]         r_wr_ptr;
    logic [PW-1:0]         r_rd_ptr;
    logic                  r_rst_done;
    logic [DATA_WIDTH-1:0] r_mem [DEPTH];

    logic w_empty;
    logic w_full;
    logic w_wr_en;
    logic w_rd_en;

    // Occupancy flags come straight from the pointers; the MSB distinguishes full from empty.
    assign w_empty = (r_wr_ptr == r_rd_ptr);
    assign w_full  = (r_wr_ptr[PW-1] != r_rd_ptr[PW-1]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);

    // Ready is purely registered state, so it never depends on s_axis_tvalid.
    assign s_axis_tready = r_rst_done & ~w_full;
    assign m_axis_tvalid = ~w_empty;
    assign m_axis_tdata  = w_empty ? '0 : r_mem[r_rd_ptr[AW-1:0]];

    assign w_wr_en = s_axis_tvalid & s_axis_tready;
    assign w_rd_en = m_axis_tvalid & m_axis_tready;

    // Pointer and reset-done state; reset discards every buffered word at once.
    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_rst_done <= 1'b0;
        end else begin
            r_rst_done <= 1'b1;
            if (w_wr_en) begin
                r_wr_ptr <= r_wr_ptr + PTR_ONE;
            end
            if (w_rd_en) begin
                r_rd_ptr <= r_rd_ptr + PTR_ONE;
            end
        end
    end

    // Storage array: written on accepted words only, never cleared.
    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            r_mem[r_wr_ptr[AW-1:0]] <= s_axis_tdata;
        end
    end

`ifdef AXIS_FIFO_LEVEL_EN
    localparam logic [PW-1:0] AF_THRESH = PW'(DEPTH - 2);

    logic [PW-1:0] w_level;

    // Modulo-2*DEPTH pointer difference yields 0..DEPTH directly.
    assign w_level     = r_wr_ptr - r_rd_ptr;
    assign level       = w_level;
    assign almost_full = (w_level >= AF_THRESH);
`endif

endmodule

// File: tb/tb_axis_sync_fifo.sv
// Directed and randomized bench for axis_sync_fifo with a queue-based reference model.
// Latency: model mirrors one-cycle fall-through timing from the observable handshake rules.
// Backpressure: both sides are driven with stalls, including a full FIFO with a held word.
module tb_axis_sync_fifo;

    localparam int DW    = 16;
    localparam int DEPTH = 16;

    logic          clk = 1'b0;
    logic          arstn;
    logic          s_axis_tvalid;
    logic          s_axis_tready;
    logic [DW-1:0] s_axis_tdata;
    logic          m_axis_tvalid;
    logic          m_axis_tready;
    logic [DW-1:0] m_axis_tdata;
`ifdef AXIS_FIFO_LEVEL_EN
    logic [4:0]    level;
    logic          almost_full;
`endif

    axis_sync_fifo #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
        .clk           (clk),
        .arstn         (arstn),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tready (s_axis_tready),
        .s_axis_tdata  (s_axis_tdata),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .m_axis_tdata  (m_axis_tdata)
`ifdef AXIS_FIFO_LEVEL_EN
        ,
        .level         (level),
        .almost_full   (almost_full)
`endif
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic timeout(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: timed out at %0t", name, $time);
    endtask

    // Reference model: an ordered queue plus a reset-done flag.
    logic [DW-1:0] mq[$];
    bit            m_rst_done;

    always @(posedge clk or negedge arstn) begin
        bit do_wr;
        bit do_rd;
        if (!arstn) begin
            mq.delete();
            m_rst_done = 1'b0;
        end else begin
            do_wr = s_axis_tvalid && m_rst_done && (mq.size() < DEPTH);
            do_rd = m_axis_tready && (mq.size() > 0);
            if (do_rd) void'(mq.pop_front());
            if (do_wr) mq.push_back(s_axis_tdata);
            m_rst_done = 1'b1;
        end
    end

    // Every-cycle comparison of the DUT outputs against the model.
    always @(negedge clk) begin
        check("m_tvalid", 32'(m_axis_tvalid), 32'(mq.size() > 0));
        check("m_tdata", 32'(m_axis_tdata), (mq.size() > 0) ? 32'(mq[0]) : 32'd0);
        check("s_tready", 32'(s_axis_tready), 32'(m_rst_done && (mq.size() < DEPTH)));
`ifdef AXIS_FIFO_LEVEL_EN
        check("level", 32'(level), 32'(mq.size()));
        check("almost_full", 32'(almost_full), 32'(mq.size() >= DEPTH - 2));
`endif
    end

    // Handshake observers used by the stimulus and the output-order checks.
    logic          s_hs;
    logic          m_hs;
    logic [DW-1:0] popped[$];

    always @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            s_hs <= 1'b0;
            m_hs <= 1'b0;
        end else begin
            s_hs <= s_axis_tvalid & s_axis_tready;
            m_hs <= m_axis_tvalid & m_axis_tready;
            if (m_axis_tvalid && m_axis_tready) popped.push_back(m_axis_tdata);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [DW-1:0] w);
        int g;
        g = 0;
        s_axis_tvalid = 1'b1;
        s_axis_tdata  = w;
        do begin
            tick();
            g++;
        end while (!s_hs && g < 200);
        s_axis_tvalid = 1'b0;
        if (!s_hs) timeout("push");
    endtask

    task automatic drain();
        int g;
        g = 0;
        m_axis_tready = 1'b1;
        while (m_axis_tvalid && g < 200) begin
            tick();
            g++;
        end
        m_axis_tready = 1'b0;
        if (m_axis_tvalid) timeout("drain");
    endtask

    function automatic logic [DW-1:0] rand_word(input int i);
        return 16'(i * 37 + 5);
    endfunction

    initial begin
        int idx;
        int cyc;
        arstn         = 1'b1;
        s_axis_tvalid = 1'b0;
        s_axis_tdata  = '0;
        m_axis_tready = 1'b0;
        #1 arstn = 1'b0;

        // Reset with tvalid high: nothing accepted, nothing presented.
        s_axis_tvalid = 1'b1;
        s_axis_tdata  = 16'hAAAA;
        repeat (3) begin
            tick();
            check("rst_s_tready", 32'(s_axis_tready), 32'd0);
            check("rst_m_tvalid", 32'(m_axis_tvalid), 32'd0);
        end
        arstn = 1'b1;
        check("rel_s_tready_pre", 32'(s_axis_tready), 32'd0);
        tick();
        check("rel_s_tready", 32'(s_axis_tready), 32'd1);
        check("rel_m_tvalid", 32'(m_axis_tvalid), 32'd0);
        s_axis_tvalid = 1'b0;
        tick();
        check("rel_no_write", 32'(m_axis_tvalid), 32'd0);

        // Single word, held under backpressure, then popped.
        popped.delete();
        push(16'h1234);
        check("one_tvalid", 32'(m_axis_tvalid), 32'd1);
        check("one_tdata", 32'(m_axis_tdata), 32'h1234);
        repeat (10) begin
            tick();
            check("hold_tvalid", 32'(m_axis_tvalid), 32'd1);
            check("hold_tdata", 32'(m_axis_tdata), 32'h1234);
        end
        m_axis_tready = 1'b1;
        tick();
        m_axis_tready = 1'b0;
        check("pop_tvalid", 32'(m_axis_tvalid), 32'd0);
        check("pop_tdata", 32'(m_axis_tdata), 32'd0);
        check("pop_count", 32'(popped.size()), 32'd1);

        // Fill to full, hold a 17th word, free one slot, accept it.
        popped.delete();
        for (int i = 0; i < 16; i++) push(16'(i));
        check("full_tready", 32'(s_axis_tready), 32'd0);
        s_axis_tvalid = 1'b1;
        s_axis_tdata  = 16'h0010;
        repeat (3) begin
            tick();
            check("full_held", 32'(s_axis_tready), 32'd0);
        end
        check("full_head", 32'(m_axis_tdata), 32'h0000);
        m_axis_tready = 1'b1;
        tick();
        m_axis_tready = 1'b0;
        check("full_pop_nohs", 32'(s_hs), 32'd0);
        check("ready_after_pop", 32'(s_axis_tready), 32'd1);
        tick();
        s_axis_tvalid = 1'b0;
        check("word17_accepted", 32'(s_hs), 32'd1);
        check("full_again", 32'(s_axis_tready), 32'd0);
        drain();
        check("fill_count", 32'(popped.size()), 32'd17);
        for (int i = 0; i < popped.size() && i < 17; i++)
            check("fill_order", 32'(popped[i]), 32'(i));

        // Continuous streaming: one word per cycle, occupancy pinned at 1.
        popped.delete();
        idx = 0;
        cyc = 0;
        s_axis_tdata  = '0;
        s_axis_tvalid = 1'b1;
        m_axis_tready = 1'b1;
        while (idx < 100 && cyc < 1000) begin
            tick();
            cyc++;
            if (s_hs) idx++;
            s_axis_tdata = 16'(idx);
            if (idx == 100) s_axis_tvalid = 1'b0;
            check("stream_occ", 32'(m_axis_tvalid), 32'd1);
        end
        check("stream_cycles", 32'(cyc), 32'd100);
        tick();
        m_axis_tready = 1'b0;
        check("stream_empty", 32'(m_axis_tvalid), 32'd0);
        check("stream_count", 32'(popped.size()), 32'd100);
        for (int i = 0; i < popped.size() && i < 100; i++)
            check("stream_order", 32'(popped[i]), 32'(i));

        // Random valid/ready for 1000 words across many pointer wraps.
        popped.delete();
        fork
            begin
                int pidx;
                int pg;
                pidx = 0;
                pg   = 0;
                s_axis_tvalid = 1'($urandom_range(0, 1));
                s_axis_tdata  = rand_word(0);
                while (pidx < 1000 && pg < 20000) begin
                    tick();
                    pg++;
                    if (s_hs) pidx++;
                    if (pidx < 1000) begin
                        s_axis_tvalid = 1'($urandom_range(0, 1));
                        s_axis_tdata  = rand_word(pidx);
                    end else begin
                        s_axis_tvalid = 1'b0;
                    end
                end
                s_axis_tvalid = 1'b0;
                if (pidx < 1000) timeout("rand_producer");
            end
            begin
                int cg;
                cg = 0;
                while (popped.size() < 1000 && cg < 20000) begin
                    m_axis_tready = 1'($urandom_range(0, 1));
                    tick();
                    cg++;
                end
                m_axis_tready = 1'b0;
                if (popped.size() < 1000) timeout("rand_consumer");
            end
        join
        check("rand_count", 32'(popped.size()), 32'd1000);
        for (int i = 0; i < popped.size() && i < 1000; i++)
            check("rand_order", 32'(popped[i]), 32'(rand_word(i)));

        // Reset between edges with words buffered.
        popped.delete();
        for (int i = 0; i < 5; i++) push(16'(16'h0100 + i));
        check("pre_rst_tvalid", 32'(m_axis_tvalid), 32'd1);
        @(posedge clk);
        #3 arstn = 1'b0;
        #1;
        check("rst_mid_tvalid", 32'(m_axis_tvalid), 32'd0);
        check("rst_mid_tdata", 32'(m_axis_tdata), 32'd0);
        check("rst_mid_tready", 32'(s_axis_tready), 32'd0);
        tick();
        tick();
        arstn = 1'b1;
        tick();
        check("post_rst_empty", 32'(m_axis_tvalid), 32'd0);
        check("post_rst_tready", 32'(s_axis_tready), 32'd1);
        push(16'hBEEF);
        check("beef_head", 32'(m_axis_tdata), 32'hBEEF);
        drain();
        check("beef_count", 32'(popped.size()), 32'd1);
        if (popped.size() > 0) check("beef_first", 32'(popped[0]), 32'hBEEF);

        tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
